// File: rtl/cu_read_cmd_scheduler.sv
// Compute-unit bulk reader: turns a (base, num_lines) request into 128B line read commands,
// throttled by outstanding credits and buffer back-pressure, and retires responses.
module cu_read_cmd_scheduler #(
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned TAG_W           = 8
) (
  input  logic             clock,
  input  logic             rstn_in,
  input  logic             enabled_in,
  input  logic             start_in,
  input  logic [63:0]      base_addr_in,
  input  logic [31:0]      num_lines_in,
  input  logic             buf_full_in,
  output logic             cmd_valid_out,
  output logic [63:0]      cmd_addr_out,
  output logic [TAG_W-1:0] cmd_tag_out,
  input  logic             rsp_valid_in,
  input  logic             rsp_error_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             error_out,
  output logic [63:0]      status_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_ERROR,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [63:0]        base_q, base_d;
  logic [31:0]        num_q, num_d;
  logic [31:0]        issued_q, issued_d;
  logic [31:0]        retired_q, retired_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic [63:0]        cmd_addr_q, cmd_addr_d;
  logic [TAG_W-1:0]   cmd_tag_q, cmd_tag_d;
  logic               error_q, error_d;
  logic [63:0]        status_q, status_d;

  logic [31:0]        outstanding;
  logic               active;
  logic               rsp_fault;
  logic               issue_ok;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    num_d       = num_q;
    issued_d    = issued_q;
    retired_d   = retired_q;
    cmd_valid_d = 1'b0;
    cmd_addr_d  = '0;
    cmd_tag_d   = '0;
    error_d     = error_q;
    status_d    = {issued_q, retired_q};

    outstanding = issued_q - retired_q;
    active      = (state_q == S_ISSUE) || (state_q == S_DRAIN) || (state_q == S_ERROR);
    rsp_fault   = rsp_valid_in && rsp_error_in;

    // Credit check uses registered counts, so a retire at the limit frees a slot one cycle later.
    issue_ok = (state_q == S_ISSUE) && enabled_in && !buf_full_in && !rsp_fault
               && (outstanding < 32'(MAX_OUTSTANDING)) && (issued_q < num_q);

    if (active && rsp_valid_in) begin
      retired_d = retired_q + 32'd1;
    end

    if (issue_ok) begin
      cmd_valid_d = 1'b1;
      cmd_addr_d  = base_q + {25'd0, issued_q, 7'd0};
      cmd_tag_d   = issued_q[TAG_W-1:0];
      issued_d    = issued_q + 32'd1;
    end

    // Faults are taken even while disabled so that no failed response is lost.
    case (state_q)
      S_IDLE: begin
        if (start_in && enabled_in) begin
          base_d    = base_addr_in & ~64'h7F;
          num_d     = num_lines_in;
          issued_d  = '0;
          retired_d = '0;
          error_d   = 1'b0;
          state_d   = (num_lines_in == 32'd0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (rsp_fault) begin
          state_d = S_ERROR;
          error_d = 1'b1;
        end else if (enabled_in && (issued_q == num_q)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (rsp_fault) begin
          state_d = S_ERROR;
          error_d = 1'b1;
        end else if (enabled_in && (retired_q == issued_q)) begin
          state_d = S_DONE;
        end
      end
      S_ERROR: begin
        if (enabled_in && (retired_q == issued_q)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (enabled_in) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rstn_in) begin
    if (!rstn_in) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      num_q       <= '0;
      issued_q    <= '0;
      retired_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_tag_q   <= '0;
      error_q     <= 1'b0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      num_q       <= num_d;
      issued_q    <= issued_d;
      retired_q   <= retired_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_tag_q   <= cmd_tag_d;
      error_q     <= error_d;
      status_q    <= status_d;
    end
  end

  assign cmd_valid_out = cmd_valid_q;
  assign cmd_addr_out  = cmd_addr_q;
  assign cmd_tag_out   = cmd_tag_q;
  assign error_out     = error_q;
  assign status_out    = status_q;
  assign done_out      = (state_q == S_DONE);
  assign busy_out      = (state_q == S_ISSUE) || (state_q == S_DRAIN) || (state_q == S_ERROR);

endmodule
